conv_window_ctrl: RTL
=====================

Name: conv_window_ctrl

Overview:
- Sequencer for the conv_2d_new line buffer: accepts a raster pixel stream, issues the buffer shift enable, tracks row/column position and flags when the KxK window taps hold a complete window.
- Gives downstream MAC logic a valid/ready window handshake with backpressure, and generates the frame control signals packet_done, finish and invalid.

Parameters:
- IMG_W, 28, image width in pixels (line length of the buffer).
- IMG_H, 28, image height in rows.
- K, 5, kernel size; a window is complete when row >= K-1 and col >= K-1.
- CW, 8, width of the position counters and coordinate outputs; must satisfy 2^CW > max(IMG_W, IMG_H).

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that arms a frame (IDLE only).
- in_valid  input  1  upstream pixel valid.
- in_ready  output  1  pixel accepted this cycle when in_valid && in_ready.
- shift_en  output  1  drives the line-buffer Valid; combinational, equals in_valid && in_ready.
- win_valid  output  1  the window at win_row/win_col is complete in the buffer.
- win_ready  input  1  downstream consumes the window.
- win_row  output  CW  output row index of the window (top-left pixel row).
- win_col  output  CW  output column index of the window.
- packet_done  output  1  one-cycle pulse when the last window of an output row is consumed.
- finish  output  1  one-cycle pulse when the last window of the frame is consumed.
- invalid  output  1  sticky error: pixel offered while not armed.
- stall_cycles  output  16  performance counter; see Optional Feature.

Behaviour:
- States:
  - IDLE: start -> ACTIVE; counters cleared.
  - ACTIVE: accept of pixel (IMG_H-1, IMG_W-1) -> DRAIN.
  - DRAIN: final window handshake -> IDLE.
  - start is ignored outside IDLE.
- Reset values: all outputs 0, state IDLE, row = col = 0, invalid = 0, stall_cycles = 0.
- Reset mid-frame: counters cleared, any pending window dropped, no finish pulse.
- in_ready = (state == ACTIVE) && !(win_valid && !win_ready).
  - A pending unconsumed window stalls input.
  - A pixel and a window handshake in the same cycle is legal (full throughput).
- On accept:
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
  - row stops at IMG_H-1; the state change to DRAIN prevents overflow.
- Window generation:
  - Latency 1 cycle: on accept of pixel (r,c) with r >= K-1 and c >= K-1, the next cycle has win_valid = 1, win_row = r-(K-1), win_col = c-(K-1).
  - win_valid, win_row and win_col hold stable until win_valid && win_ready.
  - Accepts with r < K-1 or c < K-1 (fill or line-wrap pixels) produce no window.
  - A window completing with no new window clears win_valid the next cycle.
- packet_done: pulses in the cycle after the handshake of a window with win_col == IMG_W-K.
- finish:
  - Pulses in the cycle after the handshake of window (IMG_H-K, IMG_W-K).
  - Coincides with the DRAIN -> IDLE transition; packet_done also pulses that cycle.
- invalid:
  - Set when in_valid = 1 while state is IDLE or DRAIN.
  - Cleared only by reset or an accepted start.
  - Such pixels are never shifted (shift_en = 0).
- Counts per frame with defaults: 784 accepts, 576 windows, 24 packet_done pulses, 1 finish pulse.

Optional Feature:
- Macro CONV_WIN_PERF_EN.
- Defined:
  - stall_cycles increments every ACTIVE cycle with in_valid && !in_ready.
  - It saturates at 16'hFFFF.
  - It clears on reset and on an accepted start.
- Undefined: stall_cycles is tied to 0 and no counter logic is synthesized.

Test Plan:
- Stream, no backpressure: reset, start, 784 back-to-back pixels with win_ready = 1 -> 576 windows in raster order, first (0,0) one cycle after pixel 116 is accepted, 24 packet_done pulses, 1 finish pulse, return to IDLE.
- Window backpressure: win_ready = 0 for 10 cycles at window (3,7) -> in_ready low, shift_en = 0, window held at (3,7); stall_cycles = 10 with CONV_WIN_PERF_EN defined.
- Invalid pixel: in_valid = 1 in IDLE before start -> invalid = 1 and shift_en = 0; invalid stays set until the next start clears it.
- Reset mid-frame: reset at pixel 400 -> next cycle all outputs 0, no finish; a new start and frame behaves as in the first scenario.
- Ignored start: start pulse during ACTIVE at pixel 200 -> no counter change, window sequence unaffected.
- Gapped input: in_valid toggling 1/0 every cycle, win_ready = 1 -> identical window sequence; shift_en pulses exactly 784 times.

Source files
------------

// File: rtl/conv_window_ctrl.sv
// Raster sequencer for the conv_2d_new line buffer: shift enable, KxK window handshake, frame pulses.
// Optional stall performance counter is built only when CONV_WIN_PERF_EN is defined.
module conv_window_ctrl #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned K     = 5,
  parameter int unsigned CW    = 8
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          shift_en,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [CW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          packet_done,
  output logic          finish,
  output logic          invalid,
  output logic [15:0]   stall_cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DRAIN
  } state_t;

  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_ROW  = CW'(IMG_H - 1);
  localparam logic [CW-1:0] KM1       = CW'(K - 1);
  localparam logic [CW-1:0] LAST_WCOL = CW'(IMG_W - K);
  localparam logic [CW-1:0] LAST_WROW = CW'(IMG_H - K);

  state_t          state_q, state_d;
  logic [CW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            win_valid_q, win_valid_d;
  logic [CW-1:0]   win_row_q, win_row_d;
  logic [CW-1:0]   win_col_q, win_col_d;
  logic            packet_done_q, packet_done_d;
  logic            finish_q, finish_d;
  logic            invalid_q, invalid_d;
  logic            accept;
  logic            win_hs;

  // A held, unconsumed window blocks the next pixel; a same-cycle handshake frees the slot.
  assign in_ready = (state_q == S_ACTIVE) && !(win_valid_q && !win_ready);
  assign accept   = in_valid && in_ready;
  assign win_hs   = win_valid_q && win_ready;
  assign shift_en = accept;

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    win_valid_d   = win_valid_q;
    win_row_d     = win_row_q;
    win_col_d     = win_col_q;
    invalid_d     = invalid_q;
    packet_done_d = win_hs && (win_col_q == LAST_WCOL);
    finish_d      = win_hs && (win_col_q == LAST_WCOL) && (win_row_q == LAST_WROW);

    if (win_hs) begin
      win_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ACTIVE;
          row_d     = '0;
          col_d     = '0;
          invalid_d = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (accept) begin
          if ((row_q >= KM1) && (col_q >= KM1)) begin
            win_valid_d = 1'b1;
            win_row_d   = row_q - KM1;
            win_col_d   = col_q - KM1;
          end
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (finish_d) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (in_valid && (state_q != S_ACTIVE)) begin
      invalid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      win_valid_q   <= 1'b0;
      win_row_q     <= '0;
      win_col_q     <= '0;
      packet_done_q <= 1'b0;
      finish_q      <= 1'b0;
      invalid_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      win_valid_q   <= win_valid_d;
      win_row_q     <= win_row_d;
      win_col_q     <= win_col_d;
      packet_done_q <= packet_done_d;
      finish_q      <= finish_d;
      invalid_q     <= invalid_d;
    end
  end

  assign win_valid   = win_valid_q;
  assign win_row     = win_row_q;
  assign win_col     = win_col_q;
  assign packet_done = packet_done_q;
  assign finish      = finish_q;
  assign invalid     = invalid_q;

`ifdef CONV_WIN_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start) begin
      stall_d = '0;
    end else if ((state_q == S_ACTIVE) && in_valid && !in_ready && (stall_q != '1)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
